// File: rtl/bcd_entry_ctrl_pkg.sv
// Shared types, constants and helpers for the BCD entry controller.
// Imported by the debounce sub-module and the controller top.
package bcd_entry_ctrl_pkg;

    typedef enum logic [2:0] {
        S_REF_ONES = 3'd0,
        S_REF_TENS = 3'd1,
        S_REF_HUNS = 3'd2,
        S_RD_ONES  = 3'd3,
        S_RD_TENS  = 3'd4,
        S_RD_HUNS  = 3'd5,
        S_DONE     = 3'd6
    } state_e;

    typedef struct packed {
        logic [3:0] huns;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd3_t;

    localparam logic [1:0] DIGIT_SEL_NONE = 2'd3;
    localparam int         MAX_DIGIT_DEF  = 9;

    // Counter width for a modulus, never below one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Digit-entry order; DONE is sticky here and left by a press.
    function automatic state_e next_state(input state_e s);
        state_e n;
        unique case (s)
            S_REF_ONES: n = S_REF_TENS;
            S_REF_TENS: n = S_REF_HUNS;
            S_REF_HUNS: n = S_RD_ONES;
            S_RD_ONES:  n = S_RD_TENS;
            S_RD_TENS:  n = S_RD_HUNS;
            S_RD_HUNS:  n = S_DONE;
            default:    n = S_DONE;
        endcase
        return n;
    endfunction

    // Which display digit is currently being entered.
    function automatic logic [1:0] sel_of(input state_e s);
        logic [1:0] v;
        unique case (s)
            S_REF_ONES, S_RD_ONES: v = 2'd0;
            S_REF_TENS, S_RD_TENS: v = 2'd1;
            S_REF_HUNS, S_RD_HUNS: v = 2'd2;
            default:               v = DIGIT_SEL_NONE;
        endcase
        return v;
    endfunction

    // High once the reference number is complete.
    function automatic logic is_rd(input state_e s);
        logic v;
        unique case (s)
            S_REF_ONES, S_REF_TENS, S_REF_HUNS: v = 1'b0;
            default:                            v = 1'b1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/bcd_entry_ctrl_debounce.sv
// Button synchronizer and debouncer; emits a one-cycle press pulse
// on every debounced rising edge of the raw button.
module bcd_entry_ctrl_debounce
    import bcd_entry_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST =
        CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count cycles of disagreement; flip the level once it has held.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync2_q;
            press_d = sync2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchronizer, debounced level, counter and press pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/bcd_entry_ctrl.sv
// Operator entry of a 3-digit reference and a signed 3-digit reading,
// one digit per debounced press, with blink and compare strobe.
module bcd_entry_ctrl
    import bcd_entry_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_HALF      = 25_000_000,
    parameter int MAX_DIGIT       = MAX_DIGIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic [3:0] digit_in,
    input  logic       sign_sw,
    output logic [3:0] ref_ones,
    output logic [3:0] ref_tens,
    output logic [3:0] ref_huns,
    output logic [3:0] rd_ones,
    output logic [3:0] rd_tens,
    output logic [3:0] rd_huns,
    output logic       rd_sign,
    output logic       phase,
    output logic [1:0] digit_sel,
    output logic       blink,
    output logic       cmp_start,
    output logic       err_digit,
    output logic       done
);

    localparam int BW = cnt_w(BLINK_HALF);
    localparam logic [BW-1:0] BLINK_LAST =
        BW'(BLINK_HALF - 1);
    localparam logic [3:0] DMAX = 4'(MAX_DIGIT);

    logic          press;
    logic          press_ok;

    state_e        state_q;
    state_e        state_d;
    bcd3_t         ref_q;
    bcd3_t         ref_d;
    bcd3_t         rd_q;
    bcd3_t         rd_d;
    logic          sign_q;
    logic          sign_d;
    logic          err_q;
    logic          err_d;
    logic          cmp_q;
    logic          cmp_d;
    logic          blink_q;
    logic          blink_d;
    logic [BW-1:0] blink_cnt_q;
    logic [BW-1:0] blink_cnt_d;

    bcd_entry_ctrl_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .press(press)
    );

    // Next state and digit commits for each accepted press.
    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        rd_d     = rd_q;
        sign_d   = sign_q;
        err_d    = 1'b0;
        press_ok = 1'b0;
        if (press) begin
            if (state_q == S_DONE) begin
                rd_d     = '0;
                sign_d   = 1'b0;
                state_d  = S_RD_ONES;
                press_ok = 1'b1;
            end else if (digit_in > DMAX) begin
                err_d = 1'b1;
            end else begin
                press_ok = 1'b1;
                state_d  = next_state(state_q);
                unique case (state_q)
                    S_REF_ONES: ref_d.ones = digit_in;
                    S_REF_TENS: ref_d.tens = digit_in;
                    S_REF_HUNS: ref_d.huns = digit_in;
                    S_RD_ONES:  rd_d.ones  = digit_in;
                    S_RD_TENS:  rd_d.tens  = digit_in;
                    S_RD_HUNS: begin
                        rd_d.huns = digit_in;
                        sign_d    = sign_sw;
                    end
                    default: ;
                endcase
            end
        end
        cmp_d = (state_q != S_DONE) && (state_d == S_DONE);
    end

    // Blink restarts high on a press or in DONE, else free-runs.
    always_comb begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        if (press_ok || state_d == S_DONE) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end
    end

    // State, digit registers, strobes and blink.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REF_ONES;
            ref_q       <= '0;
            rd_q        <= '0;
            sign_q      <= 1'b0;
            err_q       <= 1'b0;
            cmp_q       <= 1'b0;
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            rd_q        <= rd_d;
            sign_q      <= sign_d;
            err_q       <= err_d;
            cmp_q       <= cmp_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign ref_ones  = ref_q.ones;
    assign ref_tens  = ref_q.tens;
    assign ref_huns  = ref_q.huns;
    assign rd_ones   = rd_q.ones;
    assign rd_tens   = rd_q.tens;
    assign rd_huns   = rd_q.huns;
    assign rd_sign   = sign_q;
    assign phase     = is_rd(state_q);
    assign digit_sel = sel_of(state_q);
    assign blink     = blink_q;
    assign cmp_start = cmp_q;
    assign err_digit = err_q;
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_bcd_entry_ctrl.sv
// Scoreboard bench for bcd_entry_ctrl: stimulus queues expected
// output snapshots and blink values, a monitor pops and compares.
module tb_bcd_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       sign_sw = 1'b0;
    logic [3:0] digit_in = 4'd0;

    logic [3:0] ref_ones, ref_tens, ref_huns;
    logic [3:0] rd_ones, rd_tens, rd_huns;
    logic       rd_sign, phase, blink;
    logic       cmp_start, err_digit, done;
    logic [1:0] digit_sel;

    typedef struct packed {
        logic [3:0] r100;
        logic [3:0] r10;
        logic [3:0] r1;
        logic [3:0] d100;
        logic [3:0] d10;
        logic [3:0] d1;
        logic       sgn;
        logic       ph;
        logic [1:0] sel;
        logic       dn;
        logic       cmp;
        logic       err;
    } snap_t;

    typedef struct packed {
        int unsigned cyc;
        logic        val;
    } bexp_t;

    snap_t       exp_q[$];
    bexp_t       blk_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic        mon_en = 1'b0;
    logic        finish_req = 1'b0;
    logic        mon_done = 1'b0;
    logic        first = 1'b1;
    snap_t       cur, key, prev_key, e;
    bexp_t       b;
    snap_t       rst_snap;

    bcd_entry_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_HALF     (8),
        .MAX_DIGIT      (9)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .digit_in (digit_in),
        .sign_sw  (sign_sw),
        .ref_ones (ref_ones),
        .ref_tens (ref_tens),
        .ref_huns (ref_huns),
        .rd_ones  (rd_ones),
        .rd_tens  (rd_tens),
        .rd_huns  (rd_huns),
        .rd_sign  (rd_sign),
        .phase    (phase),
        .digit_sel(digit_sel),
        .blink    (blink),
        .cmp_start(cmp_start),
        .err_digit(err_digit),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic snap_t mk(
        input int r100, input int r10, input int r1,
        input int d100, input int d10, input int d1,
        input int sgn, input int ph, input int sel,
        input int dn, input int cmp, input int err);
        snap_t s;
        s.r100 = 4'(r100);
        s.r10  = 4'(r10);
        s.r1   = 4'(r1);
        s.d100 = 4'(d100);
        s.d10  = 4'(d10);
        s.d1   = 4'(d1);
        s.sgn  = 1'(sgn);
        s.ph   = 1'(ph);
        s.sel  = 2'(sel);
        s.dn   = 1'(dn);
        s.cmp  = 1'(cmp);
        s.err  = 1'(err);
        return s;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_blink(input int unsigned c, input logic v);
        bexp_t x;
        x.cyc = c;
        x.val = v;
        blk_q.push_back(x);
    endtask

    task automatic press(input int d, input snap_t s);
        exp_q.push_back(s);
        digit_in = 4'(d);
        btn = 1'b1;
        idle(10);
        btn = 1'b0;
        idle(10);
    endtask

    task automatic bouncy(input int d, input snap_t s);
        exp_q.push_back(s);
        digit_in = 4'(d);
        for (int i = 0; i < 5; i++) begin
            btn = (i % 2 == 0);
            idle(2);
        end
        btn = 1'b1;
        idle(12);
        btn = 1'b0;
        idle(12);
    endtask

    // Monitor: an output event is any change of the held outputs
    // or any strobe; each event must match the next expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            cur = {ref_huns, ref_tens, ref_ones,
                   rd_huns, rd_tens, rd_ones,
                   rd_sign, phase, digit_sel,
                   done, cmp_start, err_digit};
            key = cur;
            key.cmp = 1'b0;
            key.err = 1'b0;
            if (first || key != prev_key || cur.cmp || cur.err) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got %h, required none",
                             cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL event: got %h, required %h",
                                 cur, e);
                    end
                end
            end
            prev_key = key;
            first = 1'b0;
            if (blk_q.size() != 0 && blk_q[0].cyc == cyc) begin
                b = blk_q.pop_front();
                checks++;
                if (blink !== b.val) begin
                    errors++;
                    $display("FAIL blink@%0d: got %b, required %b",
                             cyc, blink, b.val);
                end
            end
            if (finish_req && !mon_done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL pending_events: got %0d left, required 0",
                             exp_q.size());
                end
                checks++;
                if (blk_q.size() != 0) begin
                    errors++;
                    $display("FAIL pending_blink: got %0d left, required 0",
                             blk_q.size());
                end
                mon_done = 1'b1;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned base;
        rst_snap = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0);
        rst = 1'b1;
        idle(3);
        exp_q.push_back(rst_snap);
        exp_blink(cyc + 1, 1'b1);
        mon_en = 1'b1;
        rst = 1'b0;
        sign_sw = 1'b1;

        // Full entry: ref 1 2 5, reading -0 3 7.
        press(5, mk(0,0,5, 0,0,0, 0,0,1, 0,0,0));
        press(2, mk(0,2,5, 0,0,0, 0,0,2, 0,0,0));
        press(1, mk(1,2,5, 0,0,0, 0,1,0, 0,0,0));
        press(7, mk(1,2,5, 0,0,7, 0,1,1, 0,0,0));
        press(3, mk(1,2,5, 0,3,7, 0,1,2, 0,0,0));
        press(0, mk(1,2,5, 0,3,7, 1,1,3, 1,1,0));
        base = cyc;
        for (int k = 1; k <= 8; k++) exp_blink(base + k, 1'b1);
        idle(10);

        // Press in DONE re-opens the reading, keeps the reference.
        press(9, mk(1,2,5, 0,0,0, 0,1,0, 0,0,0));

        // Bouncy button yields exactly one commit.
        bouncy(6, mk(1,2,5, 0,0,6, 0,1,1, 0,0,0));
        press(2, mk(1,2,5, 0,2,6, 0,1,2, 0,0,0));

        // Reset lands on the RD_HUNS press cycle.
        exp_q.push_back(rst_snap);
        digit_in = 4'd4;
        btn = 1'b1;
        idle(6);
        rst = 1'b1;
        btn = 1'b0;
        exp_blink(cyc + 1, 1'b1);
        idle(1);
        rst = 1'b0;
        idle(12);

        // Illegal digit is flagged and ignored.
        press(8,  mk(0,0,8, 0,0,0, 0,0,1, 0,0,0));
        press(12, mk(0,0,8, 0,0,0, 0,0,1, 0,0,1));
        press(4,  mk(0,4,8, 0,0,0, 0,0,2, 0,0,0));

        // Free-running blink, then a press restarts the period.
        exp_q.push_back(rst_snap);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        base = cyc;
        for (int k = 1; k <= 60; k++) begin
            int ph;
            ph = (k < 45) ? k / 8 : (k - 45) / 8;
            exp_blink(base + k, (ph % 2) == 0);
        end
        exp_q.push_back(mk(0,0,6, 0,0,0, 0,0,1, 0,0,0));
        idle(38);
        digit_in = 4'd6;
        btn = 1'b1;
        idle(12);
        btn = 1'b0;
        idle(30);

        finish_req = 1'b1;
        for (int i = 0; i < 5 && !mon_done; i++) @(negedge clk);
        if (!mon_done) begin
            $display("FAIL monitor_done: got 0, required 1");
            $fatal(1, "monitor stalled");
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
